// File: rtl/vx_warp_lock_ctrl.sv
// Warp lock controller: per-warp in-flight counters, lock bits, round-robin unlock arbitration
// and the free-running cycle counter exported to the CSR unit.
module vx_warp_lock_ctrl #(
  parameter int NUM_WARPS     = 4,
  parameter int NW_WIDTH      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int NUM_REQS      = 2,
  parameter int PEND_WIDTH    = 4,
  parameter int ALM_THRESH    = 1,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_issue_valid,
  input  logic [NW_WIDTH-1:0]          i_issue_wid,
  input  logic                         i_issue_lock,
  input  logic                         i_commit_valid,
  input  logic [NW_WIDTH-1:0]          i_commit_wid,
  output logic [NUM_WARPS-1:0]         o_pend_full,
  input  logic [NW_WIDTH-1:0]          i_alm_empty_wid,
  output logic                         o_alm_empty,
  input  logic [NUM_REQS-1:0]          i_unlock_req_valid,
  input  logic [NUM_REQS*NW_WIDTH-1:0] i_unlock_req_wid,
  output logic [NUM_REQS-1:0]          o_unlock_req_ready,
  output logic                         o_unlock_warp,
  output logic [NW_WIDTH-1:0]          o_unlock_wid,
  output logic [NUM_WARPS-1:0]         o_locked_warps,
  output logic [PERF_CTR_BITS-1:0]     o_cycles
);

  localparam int RQ_WIDTH = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] ALM_LVL  = PEND_WIDTH'(ALM_THRESH);
  localparam logic [RQ_WIDTH-1:0]   LAST_REQ = RQ_WIDTH'(NUM_REQS - 1);

  logic [PEND_WIDTH-1:0]    r_pending [NUM_WARPS];
  logic [NUM_WARPS-1:0]     r_locked;
  logic [RQ_WIDTH-1:0]      r_rrPtr;
  logic                     r_unlockWarp;
  logic [NW_WIDTH-1:0]      r_unlockWid;
  logic [PERF_CTR_BITS-1:0] r_cycles;

  logic [NUM_WARPS-1:0] w_inc;
  logic [NUM_WARPS-1:0] w_dec;
  logic                 w_grantValid;
  logic [RQ_WIDTH-1:0]  w_grantIdx;
  logic [RQ_WIDTH-1:0]  w_rrNext;
  logic [NW_WIDTH-1:0]  w_grantWid;
  logic                 w_effUnlock;
  logic [NUM_WARPS-1:0] w_lockSet;
  logic [NUM_WARPS-1:0] w_lockClr;
  int                   w_scan;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_inc[w] = i_issue_valid && (i_issue_wid == NW_WIDTH'(w));
      w_dec[w] = i_commit_valid && (i_commit_wid == NW_WIDTH'(w));
    end
  end

  // Round-robin search starting at r_rrPtr; the first valid requester wins.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    w_grantWid   = '0;
    w_scan       = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      w_scan = (int'(r_rrPtr) + k) % NUM_REQS;
      if (!w_grantValid && i_unlock_req_valid[w_scan]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = RQ_WIDTH'(w_scan);
        w_grantWid   = i_unlock_req_wid[w_scan*NW_WIDTH +: NW_WIDTH];
      end
    end
  end

  always_comb begin
    w_rrNext    = (w_grantIdx == LAST_REQ) ? '0 : w_grantIdx + 1'b1;
    w_effUnlock = w_grantValid && r_locked[w_grantWid];
    w_lockSet   = (i_issue_valid && i_issue_lock) ? (NUM_WARPS'(1) << i_issue_wid) : '0;
    w_lockClr   = w_effUnlock ? (NUM_WARPS'(1) << w_grantWid) : '0;
  end

  always_comb begin
    o_unlock_req_ready = '0;
    for (int r = 0; r < NUM_REQS; r++) begin
      o_unlock_req_ready[r] = i_reset && w_grantValid && (w_grantIdx == RQ_WIDTH'(r));
    end
  end

  // Simultaneous issue and commit on one warp cancel; otherwise saturate at both ends.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_pending[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (w_inc[w] && !w_dec[w] && (r_pending[w] != PEND_MAX)) begin
          r_pending[w] <= r_pending[w] + 1'b1;
        end else if (w_dec[w] && !w_inc[w] && (r_pending[w] != '0)) begin
          r_pending[w] <= r_pending[w] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_locked     <= '0;
      r_rrPtr      <= '0;
      r_unlockWarp <= 1'b0;
      r_unlockWid  <= '0;
      r_cycles     <= '0;
    end else begin
      r_locked     <= (r_locked & ~w_lockClr) | w_lockSet;
      r_unlockWarp <= w_effUnlock;
      r_cycles     <= r_cycles + 1'b1;
      if (w_grantValid) begin
        r_rrPtr <= w_rrNext;
      end
      if (w_effUnlock) begin
        r_unlockWid <= w_grantWid;
      end
    end
  end

  // Issuing a full warp or retiring from an empty one is a scheduler protocol error.
  always @(posedge i_clk) begin
    if (i_reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (w_inc[w] && !w_dec[w]) begin
          assert (r_pending[w] != PEND_MAX)
            else $warning("pending counter overflow on warp %0d", w);
        end
        if (w_dec[w] && !w_inc[w]) begin
          assert (r_pending[w] != '0)
            else $warning("pending counter underflow on warp %0d", w);
        end
      end
    end
  end

  always_comb begin
    o_pend_full = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      o_pend_full[w] = (r_pending[w] == PEND_MAX);
    end
  end

  assign o_alm_empty    = (r_pending[i_alm_empty_wid] <= ALM_LVL);
  assign o_unlock_warp  = r_unlockWarp;
  assign o_unlock_wid   = r_unlockWid;
  assign o_locked_warps = r_locked;
  assign o_cycles       = r_cycles;

endmodule

// File: tb/tb_vx_warp_lock_ctrl.sv
// Bench for vx_warp_lock_ctrl: directed scenarios plus a randomized run against
// an abstract model of counts, lock bits and round-robin fairness.
module tb_vx_warp_lock_ctrl;

  localparam int NW   = 4;
  localparam int NWW  = 2;
  localparam int NR   = 2;
  localparam int PMAX = 15;
  localparam int THR  = 1;
  localparam int CB   = 44;

  logic            clk = 1'b0;
  logic            resetN;
  logic            issueValid, issueLock, commitValid;
  logic [NWW-1:0]  issueWid, commitWid, almWid;
  logic [NR-1:0]   reqValid;
  logic [NR*NWW-1:0] reqWid;
  logic [NW-1:0]   oPendFull, oLocked;
  logic            oAlmEmpty, oUnlockWarp;
  logic [NR-1:0]   oReady;
  logic [NWW-1:0]  oUnlockWid;
  logic [CB-1:0]   oCycles;

  int mPend [NW];
  bit mLock [NW];
  int mRr;
  bit mPulse;
  int mUWid;
  logic [CB-1:0] mCycles;
  int nTests = 0;
  int nFail  = 0;

  vx_warp_lock_ctrl dut (
    .i_clk(clk), .i_reset(resetN),
    .i_issue_valid(issueValid), .i_issue_wid(issueWid), .i_issue_lock(issueLock),
    .i_commit_valid(commitValid), .i_commit_wid(commitWid),
    .o_pend_full(oPendFull), .i_alm_empty_wid(almWid), .o_alm_empty(oAlmEmpty),
    .i_unlock_req_valid(reqValid), .i_unlock_req_wid(reqWid), .o_unlock_req_ready(oReady),
    .o_unlock_warp(oUnlockWarp), .o_unlock_wid(oUnlockWid),
    .o_locked_warps(oLocked), .o_cycles(oCycles)
  );

  always #5 clk = ~clk;

  function automatic int mGrant();
    if (resetN !== 1'b1) return -1;
    for (int k = 0; k < NR; k++) begin
      int r = (mRr + k) % NR;
      if (reqValid[r]) return r;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] mReady();
    logic [NR-1:0] v = '0;
    int g = mGrant();
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [NW-1:0] mFull();
    logic [NW-1:0] v = '0;
    for (int w = 0; w < NW; w++) v[w] = (mPend[w] == PMAX);
    return v;
  endfunction

  function automatic logic [NW-1:0] mLocked();
    logic [NW-1:0] v = '0;
    for (int w = 0; w < NW; w++) v[w] = mLock[w];
    return v;
  endfunction

  task automatic modelEdge();
    int g, gw, iw, cw;
    if (resetN == 1'b0) begin
      for (int w = 0; w < NW; w++) begin mPend[w] = 0; mLock[w] = 0; end
      mRr = 0; mPulse = 0; mUWid = 0; mCycles = '0;
      return;
    end
    mCycles = mCycles + 1'b1;
    iw = int'(issueWid);
    cw = int'(commitWid);
    if (!(issueValid && commitValid && iw == cw)) begin
      if (issueValid && mPend[iw] < PMAX) mPend[iw]++;
      if (commitValid && mPend[cw] > 0) mPend[cw]--;
    end
    g = mGrant();
    mPulse = 0;
    if (g >= 0) begin
      gw = int'(reqWid[g*NWW +: NWW]);
      mRr = (g + 1) % NR;
      if (mLock[gw]) begin mLock[gw] = 0; mPulse = 1; mUWid = gw; end
    end
    if (issueValid && issueLock) mLock[iw] = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyStimulus(input bit iv, input int iwid, input bit lk, input bit cv, input int cwid);
    issueValid = iv; issueWid = NWW'(iwid); issueLock = lk;
    commitValid = cv; commitWid = NWW'(cwid);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    reqValid = 2'b11; reqWid = '0; almWid = '0;
    tick(); tick();
    nTests++; if (oReady !== 2'b00) begin nFail++; $display("[TB] FAIL reset_ready: got %b expected 00", oReady); end
    nTests++; if (oCycles !== '0) begin nFail++; $display("[TB] FAIL reset_cycles: got %0d expected 0", oCycles); end
    nTests++; if (oLocked !== 4'b0000) begin nFail++; $display("[TB] FAIL reset_locked: got %b expected 0000", oLocked); end
    nTests++; if (oUnlockWarp !== 1'b0) begin nFail++; $display("[TB] FAIL reset_pulse: got %b expected 0", oUnlockWarp); end
    resetN = 1'b1; reqValid = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      nTests++; if (oUnlockWarp !== 1'b0) begin nFail++; $display("[TB] FAIL idle_pulse: got %b expected 0 at cycle %0d", oUnlockWarp, i); end
    end
    nTests++; if (oCycles !== 44'd10) begin nFail++; $display("[TB] FAIL idle_cycles: got %0d expected 10", oCycles); end
    for (int w = 0; w < NW; w++) begin
      almWid = NWW'(w); #1;
      nTests++; if (oAlmEmpty !== 1'b1) begin nFail++; $display("[TB] FAIL idle_alm wid%0d: got %b expected 1", w, oAlmEmpty); end
    end
  endtask

  task automatic test_pending();
    bit expSeq [3] = '{1'b1, 1'b1, 1'b0};
    almWid = 2'd2;
    applyStimulus(1, 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      nTests++; if (oAlmEmpty !== expSeq[i]) begin nFail++; $display("[TB] FAIL issue_alm #%0d: got %b expected %b", i, oAlmEmpty, expSeq[i]); end
      tick();
    end
    applyStimulus(0, 0, 0, 1, 2);
    tick(); tick();
    applyStimulus(0, 0, 0, 0, 0); #1;
    nTests++; if (oAlmEmpty !== 1'b1) begin nFail++; $display("[TB] FAIL commit_alm: got %b expected 1", oAlmEmpty); end
    applyStimulus(1, 2, 0, 1, 2); tick();
    applyStimulus(1, 2, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0); #1;
    nTests++; if (oAlmEmpty !== 1'b0) begin nFail++; $display("[TB] FAIL same_cycle_then_issue_alm: got %b expected 0", oAlmEmpty); end
    applyStimulus(0, 0, 0, 1, 2); tick();
    applyStimulus(0, 0, 0, 0, 0); #1;
    nTests++; if (oAlmEmpty !== 1'b1) begin nFail++; $display("[TB] FAIL same_cycle_then_commit_alm: got %b expected 1", oAlmEmpty); end
    applyStimulus(0, 0, 0, 1, 2); tick();
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    applyStimulus(1, 1, 0, 0, 0);
    repeat (15) tick();
    nTests++; if (oPendFull !== 4'b0010) begin nFail++; $display("[TB] FAIL full_at_15: got %b expected 0010", oPendFull); end
    tick();
    nTests++; if (oPendFull !== 4'b0010) begin nFail++; $display("[TB] FAIL full_after_16th: got %b expected 0010", oPendFull); end
    applyStimulus(0, 0, 0, 1, 1);
    repeat (13) tick();
    almWid = 2'd1; #1;
    nTests++; if (oAlmEmpty !== 1'b0) begin nFail++; $display("[TB] FAIL saturate_drain_alm: got %b expected 0", oAlmEmpty); end
    repeat (2) tick();
    applyStimulus(0, 0, 0, 0, 0); #1;
    nTests++; if (oAlmEmpty !== 1'b1 || oPendFull !== 4'b0000) begin nFail++; $display("[TB] FAIL saturate_empty: got alm=%b full=%b expected alm=1 full=0000", oAlmEmpty, oPendFull); end
  endtask

  task automatic test_lock_unlock();
    applyStimulus(1, 3, 1, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0);
    nTests++; if (oLocked !== 4'b1000) begin nFail++; $display("[TB] FAIL lock3_set: got %b expected 1000", oLocked); end
    reqValid = 2'b01; reqWid = {2'd0, 2'd3}; #1;
    nTests++; if (oReady !== 2'b01) begin nFail++; $display("[TB] FAIL unlock3_ready: got %b expected 01", oReady); end
    tick();
    reqValid = 2'b00;
    nTests++; if (oUnlockWarp !== 1'b1 || oUnlockWid !== 2'd3 || oLocked !== 4'b0000) begin nFail++; $display("[TB] FAIL unlock3_pulse: got pulse=%b wid=%0d locked=%b expected 1 3 0000", oUnlockWarp, oUnlockWid, oLocked); end
    reqValid = 2'b10; reqWid = {2'd3, 2'd0};
    applyStimulus(0, 0, 0, 1, 3); #1;
    nTests++; if (oReady !== 2'b10) begin nFail++; $display("[TB] FAIL spurious_ready: got %b expected 10", oReady); end
    tick();
    reqValid = 2'b00; applyStimulus(0, 0, 0, 0, 0);
    nTests++; if (oUnlockWarp !== 1'b0 || oUnlockWid !== 2'd3) begin nFail++; $display("[TB] FAIL spurious_pulse: got pulse=%b wid=%0d expected 0 3", oUnlockWarp, oUnlockWid); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1, 0, 1, 0, 0); tick();
    applyStimulus(1, 1, 1, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0);
    reqValid = 2'b11; reqWid = {2'd1, 2'd0}; #1;
    nTests++; if (oReady !== 2'b01) begin nFail++; $display("[TB] FAIL rr_first_ready: got %b expected 01", oReady); end
    tick();
    reqValid = 2'b10;
    nTests++; if (oUnlockWarp !== 1'b1 || oUnlockWid !== 2'd0) begin nFail++; $display("[TB] FAIL rr_first_pulse: got pulse=%b wid=%0d expected 1 0", oUnlockWarp, oUnlockWid); end
    #1;
    nTests++; if (oReady !== 2'b10) begin nFail++; $display("[TB] FAIL rr_second_ready: got %b expected 10", oReady); end
    tick();
    reqValid = 2'b00;
    nTests++; if (oUnlockWarp !== 1'b1 || oUnlockWid !== 2'd1 || oLocked !== 4'b0000) begin nFail++; $display("[TB] FAIL rr_second_pulse: got pulse=%b wid=%0d locked=%b expected 1 1 0000", oUnlockWarp, oUnlockWid, oLocked); end
    applyStimulus(0, 0, 0, 1, 0); tick();
    nTests++; if (oUnlockWarp !== 1'b0 || oUnlockWid !== 2'd1) begin nFail++; $display("[TB] FAIL rr_pulse_end: got pulse=%b wid=%0d expected 0 1", oUnlockWarp, oUnlockWid); end
    applyStimulus(0, 0, 0, 1, 1); tick();
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic test_lock_collision();
    applyStimulus(1, 2, 1, 0, 0); tick();
    reqValid = 2'b01; reqWid = {2'd0, 2'd2}; #1;
    nTests++; if (oReady !== 2'b01) begin nFail++; $display("[TB] FAIL collide_ready: got %b expected 01", oReady); end
    tick();
    reqValid = 2'b00; applyStimulus(0, 0, 0, 1, 2);
    nTests++; if (oUnlockWarp !== 1'b1 || oUnlockWid !== 2'd2 || oLocked !== 4'b0100) begin nFail++; $display("[TB] FAIL collide_set_wins: got pulse=%b wid=%0d locked=%b expected 1 2 0100", oUnlockWarp, oUnlockWid, oLocked); end
    tick();
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 0, 1, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0);
    reqValid = 2'b01; reqWid = {2'd0, 2'd0}; resetN = 1'b0; #1;
    nTests++; if (oReady !== 2'b00) begin nFail++; $display("[TB] FAIL midreset_ready: got %b expected 00", oReady); end
    tick();
    nTests++; if (oUnlockWarp !== 1'b0 || oLocked !== 4'b0000) begin nFail++; $display("[TB] FAIL midreset_state: got pulse=%b locked=%b expected 0 0000", oUnlockWarp, oLocked); end
    resetN = 1'b1; reqValid = 2'b00;
    tick();
    nTests++; if (oUnlockWarp !== 1'b0 || oCycles !== 44'd1) begin nFail++; $display("[TB] FAIL postreset: got pulse=%b cycles=%0d expected 0 1", oUnlockWarp, oCycles); end
  endtask

  task automatic test_random();
    int g, iw, cw;
    for (int c = 0; c < 400; c++) begin
      resetN = ($urandom_range(0, 79) != 0);
      iw = $urandom_range(0, NW-1);
      cw = $urandom_range(0, NW-1);
      applyStimulus($urandom_range(0, 1) == 1 && mPend[iw] < PMAX, iw, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1 && mPend[cw] > 0, cw);
      for (int r = 0; r < NR; r++) begin
        if (!reqValid[r] && $urandom_range(0, 2) == 0) begin
          reqValid[r] = 1'b1;
          reqWid[r*NWW +: NWW] = NWW'($urandom_range(0, NW-1));
        end
      end
      almWid = NWW'($urandom_range(0, NW-1));
      #1;
      nTests++; if (oReady !== mReady()) begin nFail++; $display("[TB] FAIL rand_ready c%0d: got %b expected %b", c, oReady, mReady()); end
      nTests++; if (oAlmEmpty !== (mPend[almWid] <= THR)) begin nFail++; $display("[TB] FAIL rand_alm c%0d: got %b expected %b", c, oAlmEmpty, mPend[almWid] <= THR); end
      g = mGrant();
      tick();
      if (g >= 0) reqValid[g] = 1'b0;
      nTests++; if (oUnlockWarp !== mPulse || (mPulse && oUnlockWid !== NWW'(mUWid))) begin nFail++; $display("[TB] FAIL rand_pulse c%0d: got %b/%0d expected %b/%0d", c, oUnlockWarp, oUnlockWid, mPulse, mUWid); end
      nTests++; if (oLocked !== mLocked() || oPendFull !== mFull()) begin nFail++; $display("[TB] FAIL rand_state c%0d: got locked=%b full=%b expected %b %b", c, oLocked, oPendFull, mLocked(), mFull()); end
      nTests++; if (oCycles !== mCycles || oUnlockWid !== NWW'(mUWid)) begin nFail++; $display("[TB] FAIL rand_regs c%0d: got cycles=%0d wid=%0d expected %0d %0d", c, oCycles, oUnlockWid, mCycles, mUWid); end
    end
    resetN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pending();
    test_saturation();
    test_lock_unlock();
    test_back_to_back();
    test_lock_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
